// File: rtl/pipe_pkg.sv
// Shared types and constants for the ARM32 pipeline sequencer.
// Stage registers carry just enough of each op to drive enables and detect hazards.
package pipe_pkg;

  localparam int unsigned NREG   = 16;
  localparam int unsigned REG_AW = $clog2(NREG);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_ALT = 2'b11;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      wr1_en;
    reg_addr_t wr1_addr;
    logic      wr2_en;
    reg_addr_t wr2_addr;
    logic      is_load;
    logic      set_flags;
  } stage_t;

endpackage

// File: rtl/hazard_chk.sv
// Compares one source register against the in-flight EX/MEM/WB destinations and
// returns the forwarding select plus whether issue must wait.
module hazard_chk
  import pipe_pkg::*;
(
  input  logic      use_src,
  input  reg_addr_t src,
  input  stage_t    ex,
  input  stage_t    mem,
  input  stage_t    wb,
  output logic [1:0] sel,
  output logic      hazard
);

  logic ex_m1, ex_m2, mem_m, wb_m;
  logic unused_fields;

  assign ex_m1 = ex.valid & ex.wr1_en & (ex.wr1_addr == src);
  assign ex_m2 = ex.valid & ex.wr2_en & (ex.wr2_addr == src);
  assign mem_m = mem.valid & ((mem.wr1_en & (mem.wr1_addr == src)) |
                              (mem.wr2_en & (mem.wr2_addr == src)));
  assign wb_m  = wb.valid & ((wb.wr1_en & (wb.wr1_addr == src)) |
                             (wb.wr2_en & (wb.wr2_addr == src)));

  assign unused_fields = ^{ex.set_flags, mem.is_load, mem.set_flags, wb.is_load, wb.set_flags};

  always_comb begin
    sel    = SEL_REG;
    hazard = 1'b0;
    if (use_src) begin
      // Only a non-load EX result on port 1 is on the ALU_out bus; it is also the
      // youngest value, so it shadows any older MEM/WB writer of the same register.
      if (ex_m1 && !ex.is_load && !ex_m2) begin
        sel = SEL_ALU;
      end else if (ex_m1 || ex_m2 || mem_m || wb_m) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: issues decoded ops into EX->MEM->WB, drives datapath enables,
// forwarding selects and regfile writes, and stalls issue on unforwardable hazards.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned NREG    = 16,
  parameter int unsigned STALL_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic [$clog2(NREG)-1:0] dec_a_addr,
  input  logic [$clog2(NREG)-1:0] dec_b_addr,
  input  logic [$clog2(NREG)-1:0] dec_s_addr,
  input  logic                    dec_use_a,
  input  logic                    dec_use_b,
  input  logic                    dec_use_s,
  input  logic                    dec_a_is_pc,
  input  logic                    dec_wr1_en,
  input  logic [$clog2(NREG)-1:0] dec_wr1_addr,
  input  logic                    dec_wr2_en,
  input  logic [$clog2(NREG)-1:0] dec_wr2_addr,
  input  logic                    dec_is_load,
  input  logic                    dec_set_flags,
  input  logic                    ex_flush,
  output logic [1:0]              sel_A_in,
  output logic [1:0]              sel_B_in,
  output logic [1:0]              sel_shift_in,
  output logic                    en_A,
  output logic                    en_B,
  output logic                    en_S,
  output logic                    en_out1,
  output logic                    en_status1,
  output logic                    en_out2,
  output logic                    en_status2,
  output logic                    w_en1,
  output logic [$clog2(NREG)-1:0] w_addr1,
  output logic                    w_en2,
  output logic [$clog2(NREG)-1:0] w_addr2,
  output logic                    sel_w_data,
  output logic                    stall,
  output logic [STALL_W-1:0]      stall_cnt
);

  stage_t ex_q, mem_q, wb_q, ex_d;
  logic [1:0] sel_a, sel_b, sel_s;
  logic haz_a, haz_b, haz_s, hazard, valid_in;

  // Nothing is accepted while reset is held, even if the decoder keeps presenting.
  assign valid_in = dec_valid & ~rst;

  hazard_chk u_chk_a (
    .use_src (dec_use_a & ~dec_a_is_pc),
    .src     (dec_a_addr),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (sel_a),
    .hazard  (haz_a)
  );

  hazard_chk u_chk_b (
    .use_src (dec_use_b),
    .src     (dec_b_addr),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (sel_b),
    .hazard  (haz_b)
  );

  hazard_chk u_chk_s (
    .use_src (dec_use_s),
    .src     (dec_s_addr),
    .ex      (ex_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (sel_s),
    .hazard  (haz_s)
  );

  assign hazard    = haz_a | haz_b | haz_s;
  // A flush squashes the ID op outright, so it is not counted as a stall.
  assign stall     = valid_in & hazard & ~ex_flush;
  assign dec_ready = valid_in & ~hazard & ~ex_flush;
  assign en_A      = dec_ready;
  assign en_B      = dec_ready;
  assign en_S      = dec_ready;

  always_comb begin
    sel_A_in     = SEL_REG;
    sel_B_in     = SEL_REG;
    sel_shift_in = SEL_REG;
    if (valid_in) begin
      sel_A_in     = dec_a_is_pc ? SEL_ALT : sel_a;
      sel_B_in     = sel_b;
      sel_shift_in = dec_use_s ? sel_s : SEL_ALT;
    end
  end

  always_comb begin
    ex_d = '0;
    if (dec_ready) begin
      ex_d.valid     = 1'b1;
      ex_d.wr1_en    = dec_wr1_en;
      ex_d.wr1_addr  = dec_wr1_addr;
      ex_d.wr2_en    = dec_wr2_en;
      ex_d.wr2_addr  = dec_wr2_addr;
      ex_d.is_load   = dec_is_load;
      ex_d.set_flags = dec_set_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall && (stall_cnt != {STALL_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign en_out1    = ex_q.valid;
  assign en_status1 = ex_q.valid & ex_q.set_flags;
  assign en_out2    = mem_q.valid;
  assign en_status2 = mem_q.valid & mem_q.set_flags;
  assign w_en1      = wb_q.valid & wb_q.wr1_en;
  assign w_addr1    = wb_q.wr1_addr;
  assign w_en2      = wb_q.valid & wb_q.wr2_en;
  assign w_addr2    = wb_q.wr2_addr;
  assign sel_w_data = wb_q.is_load;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: forwarding, load-use and distance hazards, flush,
// PC/shift selects, stall counter saturation and asynchronous reset.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_ready;
  logic [3:0] dec_a_addr, dec_b_addr, dec_s_addr;
  logic       dec_use_a, dec_use_b, dec_use_s, dec_a_is_pc;
  logic       dec_wr1_en, dec_wr2_en;
  logic [3:0] dec_wr1_addr, dec_wr2_addr;
  logic       dec_is_load, dec_set_flags, ex_flush;
  logic [1:0] sel_A_in, sel_B_in, sel_shift_in;
  logic       en_A, en_B, en_S, en_out1, en_status1, en_out2, en_status2;
  logic       w_en1, w_en2, sel_w_data, stall;
  logic [3:0] w_addr1, w_addr2;
  logic [15:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.NREG(16), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_a_addr(dec_a_addr), .dec_b_addr(dec_b_addr), .dec_s_addr(dec_s_addr),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_use_s(dec_use_s),
    .dec_a_is_pc(dec_a_is_pc), .dec_wr1_en(dec_wr1_en), .dec_wr1_addr(dec_wr1_addr),
    .dec_wr2_en(dec_wr2_en), .dec_wr2_addr(dec_wr2_addr), .dec_is_load(dec_is_load),
    .dec_set_flags(dec_set_flags), .ex_flush(ex_flush), .sel_A_in(sel_A_in),
    .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in), .en_A(en_A), .en_B(en_B),
    .en_S(en_S), .en_out1(en_out1), .en_status1(en_status1), .en_out2(en_out2),
    .en_status2(en_status2), .w_en1(w_en1), .w_addr1(w_addr1), .w_en2(w_en2),
    .w_addr2(w_addr2), .sel_w_data(sel_w_data), .stall(stall), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_use_a = 0; dec_a_addr = 0; dec_use_b = 0; dec_b_addr = 0;
    dec_use_s = 0; dec_s_addr = 0; dec_a_is_pc = 0; dec_wr1_en = 0; dec_wr1_addr = 0;
    dec_wr2_en = 0; dec_wr2_addr = 0; dec_is_load = 0; dec_set_flags = 0;
  endtask

  task automatic op(input logic ua, input logic [3:0] a, input logic ub, input logic [3:0] b,
                    input logic us, input logic [3:0] s, input logic pc,
                    input logic w1e, input logic [3:0] w1, input logic w2e,
                    input logic [3:0] w2, input logic ld, input logic sf);
    dec_valid = 1; dec_use_a = ua; dec_a_addr = a; dec_use_b = ub; dec_b_addr = b;
    dec_use_s = us; dec_s_addr = s; dec_a_is_pc = pc; dec_wr1_en = w1e; dec_wr1_addr = w1;
    dec_wr2_en = w2e; dec_wr2_addr = w2; dec_is_load = ld; dec_set_flags = sf;
  endtask

  initial begin
    rst = 1; ex_flush = 0; idle();
    #1;
    chk("rst_ready", dec_ready, 0);
    chk("rst_en_out1", en_out1, 0);
    chk("rst_w_en1", w_en1, 0);
    chk("rst_w_en2", w_en2, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_sel_a", sel_A_in, 0);
    @(negedge clk); rst = 0;

    // Back-to-back ALU forwarding
    @(negedge clk); op(1, 5, 1, 6, 0, 0, 0, 1, 1, 0, 0, 0, 1); #1;
    chk("b2b_ready0", dec_ready, 1);
    chk("b2b_en_a", en_A, 1);
    @(negedge clk); op(1, 1, 0, 0, 1, 7, 0, 1, 2, 0, 0, 0, 0); #1;
    chk("b2b_sel_a", sel_A_in, 2'b01);
    chk("b2b_stall", stall, 0);
    chk("b2b_ready1", dec_ready, 1);
    chk("b2b_en_out1", en_out1, 1);
    chk("b2b_en_st1", en_status1, 1);
    @(negedge clk); idle(); #1;
    chk("b2b_en_out2", en_out2, 1);
    chk("b2b_en_st1_sub", en_status1, 0);
    chk("b2b_en_st2", en_status2, 1);
    @(negedge clk); #1;
    chk("b2b_wen_add", w_en1, 1);
    chk("b2b_waddr_add", w_addr1, 1);
    chk("b2b_wdata_sel", sel_w_data, 0);
    @(negedge clk); #1;
    chk("b2b_waddr_sub", w_addr1, 2);
    @(negedge clk); #1;
    chk("b2b_drained", w_en1, 0);

    // Load-use: LDR r3 with base writeback r7, then ADD reads r3 on B
    @(negedge clk); op(1, 7, 0, 0, 0, 0, 0, 1, 3, 1, 7, 1, 0); #1;
    chk("lu_ready_ldr", dec_ready, 1);
    @(negedge clk); op(0, 0, 1, 3, 0, 0, 0, 1, 8, 0, 0, 0, 0); #1;
    chk("lu_stall_ex", stall, 1);
    chk("lu_ready_ex", dec_ready, 0);
    chk("lu_sel_b_ex", sel_B_in, 0);
    @(negedge clk); #1;
    chk("lu_stall_mem", stall, 1);
    @(negedge clk); #1;
    chk("lu_stall_wb", stall, 1);
    chk("lu_wen1", w_en1, 1);
    chk("lu_waddr1", w_addr1, 3);
    chk("lu_wdata_sel", sel_w_data, 1);
    chk("lu_wen2", w_en2, 1);
    chk("lu_waddr2", w_addr2, 7);
    @(negedge clk); #1;
    chk("lu_issue_stall", stall, 0);
    chk("lu_issue_ready", dec_ready, 1);
    chk("lu_issue_sel_b", sel_B_in, 0);
    chk("lu_cnt", stall_cnt, 3);
    repeat (3) begin @(negedge clk); idle(); end

    // Distance-2 hazard on r4, then distance 4 with no stall
    @(negedge clk); op(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0); #1;
    chk("d2_ready_w", dec_ready, 1);
    @(negedge clk); op(1, 10, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0); #1;
    chk("d2_ready_ind", dec_ready, 1);
    @(negedge clk); op(1, 4, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0); #1;
    chk("d2_stall_mem", stall, 1);
    @(negedge clk); #1;
    chk("d2_stall_wb", stall, 1);
    @(negedge clk); #1;
    chk("d2_issue", dec_ready, 1);
    chk("d2_sel_a", sel_A_in, 0);
    chk("d2_cnt", stall_cnt, 5);
    @(negedge clk); op(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    repeat (3) begin @(negedge clk); op(1, 10, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0); end
    @(negedge clk); op(1, 4, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0); #1;
    chk("d4_stall", stall, 0);
    chk("d4_ready", dec_ready, 1);
    chk("d4_cnt", stall_cnt, 5);
    // EX writes r13 through port 2: cannot forward
    @(negedge clk); op(0, 0, 0, 0, 0, 0, 0, 1, 14, 1, 13, 0, 0);
    @(negedge clk); op(0, 0, 0, 0, 1, 13, 0, 1, 15, 0, 0, 0, 0); #1;
    chk("wr2_stall", stall, 1);
    chk("wr2_sel_s", sel_shift_in, 0);
    @(negedge clk); idle(); #1;
    chk("nv_stall", stall, 0);
    chk("wr2_cnt", stall_cnt, 6);
    repeat (3) begin @(negedge clk); idle(); end

    // Flush while a dependent op is stalled
    @(negedge clk); op(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0);
    @(negedge clk); op(1, 3, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0); #1;
    chk("fl_pre_stall", stall, 1);
    @(negedge clk); ex_flush = 1; #1;
    chk("fl_ready", dec_ready, 0);
    chk("fl_stall", stall, 0);
    chk("fl_en_a", en_A, 0);
    @(negedge clk); ex_flush = 0; idle(); #1;
    chk("fl_cnt", stall_cnt, 7);
    chk("fl_ex_bubble", en_out1, 0);
    chk("fl_ldr_wb", w_en1, 1);
    @(negedge clk); op(1, 10, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0); ex_flush = 1; #1;
    chk("fl2_ready", dec_ready, 0);
    @(negedge clk); ex_flush = 0; idle(); #1;
    chk("fl2_bubble", en_out1, 0);

    // PC operand and unused shift
    @(negedge clk); op(0, 0, 0, 0, 0, 0, 0, 1, 14, 0, 0, 0, 0);
    @(negedge clk); op(1, 14, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0); #1;
    chk("pc_sel_a", sel_A_in, 2'b11);
    chk("pc_sel_s", sel_shift_in, 2'b11);
    chk("pc_sel_b", sel_B_in, 2'b00);
    chk("pc_stall", stall, 0);
    @(negedge clk); dec_valid = 0; #1;
    chk("nv_sel_s", sel_shift_in, 2'b00);
    chk("nv_sel_a", sel_A_in, 2'b00);
    repeat (3) begin @(negedge clk); idle(); end

    // Saturation: self-dependent load chain stalls 3 of every 4 cycles
    @(negedge clk); op(1, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0);
    repeat (87400) @(posedge clk);
    @(negedge clk); #1;
    chk("sat_cnt", stall_cnt, 16'hFFFF);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk("sat_hold", stall_cnt, 16'hFFFF);

    // Reset with three ops in flight
    @(negedge clk); idle();
    repeat (4) @(negedge clk);
    op(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    @(negedge clk); op(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1);
    @(negedge clk); op(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1);
    @(negedge clk); idle(); #1;
    chk("mr_pre_out1", en_out1, 1);
    chk("mr_pre_out2", en_out2, 1);
    chk("mr_pre_wen1", w_en1, 1);
    op(1, 9, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0); rst = 1; #1;
    chk("mr_out1", en_out1, 0);
    chk("mr_st1", en_status1, 0);
    chk("mr_out2", en_out2, 0);
    chk("mr_wen1", w_en1, 0);
    chk("mr_wen2", w_en2, 0);
    chk("mr_cnt", stall_cnt, 0);
    chk("mr_ready", dec_ready, 0);
    chk("mr_en_a", en_A, 0);
    @(negedge clk); rst = 0; idle(); #1;
    chk("mr_after0", w_en1, 0);
    @(negedge clk); #1;
    chk("mr_after1", w_en1, 0);
    @(negedge clk); #1;
    chk("mr_after2", w_en1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
